bcd_countdown_timer: RTL and testbench
======================================

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning CLOCK_50 cycles per 0.01 s count step (minimum 2).
REQ-002 SHALL have port CLOCK_50  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port PRESET  input  16  four BCD digits, [15:12] = 10 s … [3:0] = 0.01 s.
REQ-005 SHALL have port LOAD  input  1  active-high level from a debounced switch/key, asynchronous to CLOCK_50.
REQ-006 SHALL have port START  input  1  active-high level from a debounced key, asynchronous; each rising edge toggles run/pause.
REQ-007 SHALL have port BCD_OUT  output  16  current count, same digit order as PRESET.
REQ-008 SHALL have port RUNNING  output  1  high only in state RUN.
REQ-009 SHALL have port DONE  output  1  high only in state EXPIRED.
REQ-010 SHALL have ports HEX3, HEX2, HEX1, HEX0  output  [0:6] each  active-low segments for BCD_OUT digits 3..0.

Function
REQ-011 SHALL pass LOAD and START through a 2-flop synchronizer each, then detect rising edges; an edge is acted on in the cycle after detection (input edge to state change = 3 cycles).
REQ-012 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-013 SHALL on a LOAD edge in any state: count <= PRESET, prescaler <= 0, state <= IDLE.
REQ-014 SHALL clamp any PRESET digit > 9 to 9 when loading.
REQ-015 SHALL on a START edge: IDLE -> RUN if count != 0000, IDLE -> EXPIRED if count == 0000; RUN -> PAUSE; PAUSE -> RUN; EXPIRED ignores START.
REQ-016 SHALL give LOAD priority when LOAD and START edges occur in the same cycle.
REQ-017 SHALL advance the prescaler only in RUN, counting 0..TICK_DIV-1 and wrapping to 0; the wrap cycle is the tick.
REQ-018 SHALL hold the prescaler value through PAUSE, so resuming continues the partial interval.
REQ-019 SHALL decrement count by one on each tick: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit; borrow stops at the first nonzero digit.
REQ-020 SHALL enter EXPIRED in the cycle after the tick that makes count 0000; count never wraps below 0000.
REQ-021 SHALL hold count and state in EXPIRED until LOAD or RESET.
REQ-022 SHALL decode each BCD_OUT digit combinationally to segments: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=1100000, 7=0001111, 8=0000000, 9=0001100, other=1111111.

Reset
REQ-023 SHALL on RESET asynchronously set state IDLE, count 0000, prescaler 0, synchronizer and edge flops 0.
REQ-024 SHALL drive RUNNING=0, DONE=0, BCD_OUT=16'h0000, HEX3..HEX0=0000001 while in reset.
REQ-025 SHALL not report an edge on the first cycle after reset release if LOAD or START is already high (edge flops reset to 0 and sync must see a 0->1 transition).

Structure
REQ-026 SHALL place the state encoding, BCD digit width (4) and segment constants in a shared package timer_pkg.
REQ-027 SHALL instantiate the existing bcd7seg decoder four times as the only sub-module; a per-digit borrow decrement function belongs in timer_pkg.

Verification (TICK_DIV=4)
REQ-028 SHALL check: PRESET=16'h0012, LOAD pulse, START pulse -> RUNNING=1; BCD_OUT 0011, 0010, 0009 at 4-cycle spacing; ... 0000 then DONE=1, RUNNING=0.
REQ-029 SHALL check: load 16'h1000, run one tick -> BCD_OUT=0999 (full borrow chain).
REQ-030 SHALL check: run from 0005, START after 2 prescaler cycles -> PAUSE, count frozen 20 cycles; START again -> next decrement after exactly 2 more cycles.
REQ-031 SHALL check: PRESET=16'hFA3C, LOAD -> BCD_OUT=9939; PRESET=0000, LOAD, START -> DONE=1 with no RUN.
REQ-032 SHALL check: LOAD and START rising together while RUN at 0042 with PRESET=0100 -> IDLE, BCD_OUT=0100, RUNNING=0.
REQ-033 SHALL check: RESET asserted mid-RUN asynchronously (between clock edges) -> outputs at reset values immediately; START held high across release produces no run.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// State encoding, digit width, segment patterns, BCD clamp/decrement.
package timer_pkg;

  localparam int DIGIT_W = 4;
  localparam int NDIGITS = 4;
  localparam int BCD_W   = DIGIT_W * NDIGITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] digit;
    logic               borrow;
  } dec_t;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b1100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0001100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d
  );
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [BCD_W-1:0] clamp_bcd(
    input logic [BCD_W-1:0] v
  );
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < NDIGITS; i++)
      r[i*DIGIT_W +: DIGIT_W] = clamp_digit(v[i*DIGIT_W +: DIGIT_W]);
    return r;
  endfunction

  // One digit of a ripple-borrow decrement.
  function automatic dec_t dec_digit(
    input logic [DIGIT_W-1:0] d,
    input logic               bin
  );
    dec_t r;
    if (!bin) begin
      r.digit  = d;
      r.borrow = 1'b0;
    end else if (d == 4'd0) begin
      r.digit  = 4'd9;
      r.borrow = 1'b1;
    end else begin
      r.digit  = d - 4'd1;
      r.borrow = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] dec_bcd(
    input logic [BCD_W-1:0] v
  );
    logic [BCD_W-1:0] r;
    logic             b;
    dec_t             t;
    r = '0;
    b = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      t = dec_digit(v[i*DIGIT_W +: DIGIT_W], b);
      r[i*DIGIT_W +: DIGIT_W] = t.digit;
      b = t.borrow;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// BCD digit to active-low seven-segment decoder, purely combinational.
// Ports: bcd (4-bit digit in), seg ([0:6] = a..g, active low).
module bcd7seg
  import timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  output logic [0:6]         seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Four-digit BCD countdown timer (0.01 s steps) with load/start keys.
// Ports: CLOCK_50, RESET, PRESET, LOAD, START in; BCD_OUT, RUNNING, DONE, HEX3..0 out.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 500000
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [15:0] PRESET,
  input  logic        LOAD,
  input  logic        START,
  output logic [15:0] BCD_OUT,
  output logic        RUNNING,
  output logic        DONE,
  output logic [0:6]  HEX3,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX0
);
  import timer_pkg::*;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic load_s1, load_s2, load_d, load_arm;
  logic start_s1, start_s2, start_d, start_arm;
  logic vld1, vld2;
  logic load_rise, start_rise;

  state_t           state;
  logic [BCD_W-1:0] count;
  logic [BCD_W-1:0] count_dec;
  logic [PW-1:0]    presc;

  // vld1/vld2 mark when the sync stages hold real samples instead of
  // reset fill; an input must be seen low before its edges are armed,
  // so a key held through reset release never fires.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      load_s1   <= 1'b0;
      load_s2   <= 1'b0;
      load_d    <= 1'b0;
      load_arm  <= 1'b0;
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_d   <= 1'b0;
      start_arm <= 1'b0;
      vld1      <= 1'b0;
      vld2      <= 1'b0;
    end else begin
      load_s1   <= LOAD;
      load_s2   <= load_s1;
      load_d    <= load_s2;
      start_s1  <= START;
      start_s2  <= start_s1;
      start_d   <= start_s2;
      vld1      <= 1'b1;
      vld2      <= vld1;
      load_arm  <= load_arm | (vld2 & ~load_s2);
      start_arm <= start_arm | (vld2 & ~start_s2);
    end
  end

  assign load_rise  = load_arm & load_s2 & ~load_d;
  assign start_rise = start_arm & start_s2 & ~start_d;

  assign count_dec = dec_bcd(count);

  // Key events outrank the prescaler; a pausing START freezes it in place.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      count <= '0;
      presc <= '0;
    end else if (load_rise) begin
      state <= ST_IDLE;
      count <= clamp_bcd(PRESET);
      presc <= '0;
    end else if (start_rise) begin
      unique case (state)
        ST_IDLE:    state <= (count == '0) ? ST_EXPIRED : ST_RUN;
        ST_RUN:     state <= ST_PAUSE;
        ST_PAUSE:   state <= ST_RUN;
        ST_EXPIRED: state <= ST_EXPIRED;
      endcase
    end else if (state == ST_RUN) begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        if (count != '0) begin
          count <= count_dec;
          if (count_dec == '0)
            state <= ST_EXPIRED;
        end else begin
          state <= ST_EXPIRED;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  assign BCD_OUT = count;
  assign RUNNING = (state == ST_RUN);
  assign DONE    = (state == ST_EXPIRED);

  bcd7seg u_seg3 (.bcd(count[15:12]), .seg(HEX3));
  bcd7seg u_seg2 (.bcd(count[11:8]),  .seg(HEX2));
  bcd7seg u_seg1 (.bcd(count[7:4]),   .seg(HEX1));
  bcd7seg u_seg0 (.bcd(count[3:0]),   .seg(HEX0));

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer with TICK_DIV = 4.
// Each task drives one scenario and compares against hand-computed values.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] preset;
  logic        load;
  logic        start;
  logic [15:0] bcd_out;
  logic        running;
  logic        done;
  logic [0:6]  hex3, hex2, hex1, hex0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICK_DIV(4)) dut (
    .CLOCK_50(clk),
    .RESET(rst),
    .PRESET(preset),
    .LOAD(load),
    .START(start),
    .BCD_OUT(bcd_out),
    .RUNNING(running),
    .DONE(done),
    .HEX3(hex3),
    .HEX2(hex2),
    .HEX1(hex1),
    .HEX0(hex0)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse lands in state 3 edges after it rises; returns just after that edge.
  task automatic press_load(input logic [15:0] v);
    preset = v;
    load = 1'b1;
    step(1);
    load = 1'b0;
    step(2);
  endtask

  task automatic press_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    nvec++;
    if (bcd_out !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL rst_hold bcd=%h run=%b done=%b exp 0000/0/0", bcd_out, running, done);
    end
    nvec++;
    if (hex0 !== 7'b0000001 || hex3 !== 7'b0000001) begin
      nerr++;
      $display("FAIL rst_hex hex3=%b hex0=%b exp 0000001", hex3, hex0);
    end
    #3 rst = 1'b0;
    step(4);
    nvec++;
    if (bcd_out !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL rst_release bcd=%h run=%b done=%b exp 0000/0/0", bcd_out, running, done);
    end
  endtask

  task automatic test_countdown;
    logic [15:0] exp_tbl [9];
    exp_tbl = '{16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004,
                16'h0003, 16'h0002, 16'h0001, 16'h0000};
    press_load(16'h0012);
    nvec++;
    if (bcd_out !== 16'h0012 || running !== 1'b0) begin
      nerr++;
      $display("FAIL cd_load bcd=%h run=%b exp 0012/0", bcd_out, running);
    end
    nvec++;
    if (hex1 !== 7'b1001111 || hex0 !== 7'b0010010 || hex2 !== 7'b0000001) begin
      nerr++;
      $display("FAIL cd_hex hex2=%b hex1=%b hex0=%b exp 0000001/1001111/0010010", hex2, hex1, hex0);
    end
    press_start;
    nvec++;
    if (running !== 1'b1 || bcd_out !== 16'h0012) begin
      nerr++;
      $display("FAIL cd_start run=%b bcd=%h exp 1/0012", running, bcd_out);
    end
    step(3);
    nvec++;
    if (bcd_out !== 16'h0012) begin
      nerr++;
      $display("FAIL cd_pre_tick bcd=%h exp 0012", bcd_out);
    end
    step(1);
    nvec++;
    if (bcd_out !== 16'h0011) begin
      nerr++;
      $display("FAIL cd_0011 bcd=%h exp 0011", bcd_out);
    end
    step(4);
    nvec++;
    if (bcd_out !== 16'h0010) begin
      nerr++;
      $display("FAIL cd_0010 bcd=%h exp 0010", bcd_out);
    end
    step(4);
    nvec++;
    if (bcd_out !== 16'h0009) begin
      nerr++;
      $display("FAIL cd_0009 bcd=%h exp 0009", bcd_out);
    end
    for (int i = 0; i < 9; i++) begin
      step(4);
      nvec++;
      if (bcd_out !== exp_tbl[i]) begin
        nerr++;
        $display("FAIL cd_seq%0d bcd=%h exp %h", i, bcd_out, exp_tbl[i]);
      end
    end
    nvec++;
    if (done !== 1'b1 || running !== 1'b0) begin
      nerr++;
      $display("FAIL cd_expire done=%b run=%b exp 1/0", done, running);
    end
    step(12);
    press_start;
    nvec++;
    if (bcd_out !== 16'h0000 || done !== 1'b1) begin
      nerr++;
      $display("FAIL cd_hold bcd=%h done=%b exp 0000/1", bcd_out, done);
    end
  endtask

  task automatic test_borrow;
    press_load(16'h1000);
    nvec++;
    if (bcd_out !== 16'h1000 || done !== 1'b0) begin
      nerr++;
      $display("FAIL br_load bcd=%h done=%b exp 1000/0", bcd_out, done);
    end
    press_start;
    step(4);
    nvec++;
    if (bcd_out !== 16'h0999) begin
      nerr++;
      $display("FAIL br_chain bcd=%h exp 0999", bcd_out);
    end
  endtask

  task automatic test_pause;
    press_load(16'h0005);
    press_start;
    press_start;
    nvec++;
    if (running !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0005) begin
      nerr++;
      $display("FAIL pz_enter run=%b done=%b bcd=%h exp 0/0/0005", running, done, bcd_out);
    end
    step(20);
    nvec++;
    if (bcd_out !== 16'h0005 || running !== 1'b0) begin
      nerr++;
      $display("FAIL pz_frozen bcd=%h run=%b exp 0005/0", bcd_out, running);
    end
    press_start;
    nvec++;
    if (running !== 1'b1) begin
      nerr++;
      $display("FAIL pz_resume run=%b exp 1", running);
    end
    step(1);
    nvec++;
    if (bcd_out !== 16'h0005) begin
      nerr++;
      $display("FAIL pz_partial bcd=%h exp 0005", bcd_out);
    end
    step(1);
    nvec++;
    if (bcd_out !== 16'h0004) begin
      nerr++;
      $display("FAIL pz_tick bcd=%h exp 0004", bcd_out);
    end
  endtask

  task automatic test_clamp_zero;
    press_load(16'hFA3C);
    nvec++;
    if (bcd_out !== 16'h9939 || running !== 1'b0) begin
      nerr++;
      $display("FAIL cl_value bcd=%h run=%b exp 9939/0", bcd_out, running);
    end
    nvec++;
    if (hex3 !== 7'b0001100 || hex2 !== 7'b0001100 ||
        hex1 !== 7'b0000110 || hex0 !== 7'b0001100) begin
      nerr++;
      $display("FAIL cl_hex %b %b %b %b exp 0001100 0001100 0000110 0001100", hex3, hex2, hex1, hex0);
    end
    press_load(16'h0000);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      start = 1'b0;
      nvec++;
      if (running !== 1'b0) begin
        nerr++;
        $display("FAIL zr_norun%0d run=%b exp 0", i, running);
      end
    end
    nvec++;
    if (done !== 1'b1 || bcd_out !== 16'h0000) begin
      nerr++;
      $display("FAIL zr_done done=%b bcd=%h exp 1/0000", done, bcd_out);
    end
  endtask

  task automatic test_back_to_back;
    press_load(16'h0042);
    press_start;
    preset = 16'h0100;
    load = 1'b1;
    start = 1'b1;
    step(1);
    load = 1'b0;
    start = 1'b0;
    step(2);
    nvec++;
    if (bcd_out !== 16'h0100 || running !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL bb_prio bcd=%h run=%b done=%b exp 0100/0/0", bcd_out, running, done);
    end
    step(8);
    nvec++;
    if (bcd_out !== 16'h0100 || running !== 1'b0) begin
      nerr++;
      $display("FAIL bb_idle bcd=%h run=%b exp 0100/0", bcd_out, running);
    end
  endtask

  task automatic test_async_reset;
    press_load(16'h0042);
    press_start;
    step(2);
    #3 rst = 1'b1;
    #1;
    nvec++;
    if (bcd_out !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL ar_imm bcd=%h run=%b done=%b exp 0000/0/0", bcd_out, running, done);
    end
    nvec++;
    if (hex1 !== 7'b0000001 || hex2 !== 7'b0000001) begin
      nerr++;
      $display("FAIL ar_hex hex2=%b hex1=%b exp 0000001", hex2, hex1);
    end
    start = 1'b1;
    step(3);
    #3 rst = 1'b0;
    step(10);
    nvec++;
    if (running !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
      nerr++;
      $display("FAIL ar_held run=%b done=%b bcd=%h exp 0/0/0000", running, done, bcd_out);
    end
    start = 1'b0;
    step(4);
    press_start;
    nvec++;
    if (done !== 1'b1 || running !== 1'b0) begin
      nerr++;
      $display("FAIL ar_rearm done=%b run=%b exp 1/0", done, running);
    end
  endtask

  initial begin
    rst    = 1'b1;
    preset = 16'h0000;
    load   = 1'b0;
    start  = 1'b0;
    test_reset;
    test_countdown;
    test_borrow;
    test_pause;
    test_clamp_zero;
    test_back_to_back;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
